// File: rtl/wb_result_checker_pkg.sv
// Shared types for the writeback/store result checker: entry layout, kinds and FSM states.
package wb_checker_pkg;

    // Table entries are sized to the default bus widths; wider buses need these widened too.
    localparam int CHK_XLEN = 32;
    localparam int CHK_AW   = 10;

    typedef enum logic {
        CHK_REG = 1'b0,
        CHK_MEM = 1'b1
    } check_kind_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chk_state_e;

    typedef struct packed {
        logic                valid;
        check_kind_e         kind;
        logic [CHK_AW-1:0]   addr;
        logic [CHK_XLEN-1:0] expected;
    } check_entry_t;

    function automatic logic accepts_cmd(chk_state_e s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/wb_result_checker_if.sv
// Configuration, snoop and result signals of the result checker, with both sides as modports.
interface wb_result_checker_if #(
    parameter int NUM_CHECKS = 16,
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int DM_AW      = 10
);
    import wb_checker_pkg::*;

    localparam int IDX_W = $clog2(NUM_CHECKS);
    localparam int CNT_W = $clog2(NUM_CHECKS + 1);

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic              cfg_valid;
    check_kind_e       cfg_kind;
    logic [DM_AW-1:0]  cfg_addr;
    logic [XLEN-1:0]   cfg_data;
    logic              start;
    logic              halt;
    logic              rf_we;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wdata;
    logic              dm_we;
    logic [DM_AW-1:0]  dm_addr;
    logic [XLEN-1:0]   dm_wdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  pass_count;
    logic [CNT_W-1:0]  fail_count;
    logic [IDX_W-1:0]  first_fail_idx;
    logic [15:0]       cycle_count;

    modport master (
        output cfg_we, cfg_idx, cfg_valid, cfg_kind, cfg_addr, cfg_data, start, halt,
               rf_we, rf_rd, rf_wdata, dm_we, dm_addr, dm_wdata,
        input  busy, done, pass, pass_count, fail_count, first_fail_idx, cycle_count
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_valid, cfg_kind, cfg_addr, cfg_data, start, halt,
               rf_we, rf_rd, rf_wdata, dm_we, dm_addr, dm_wdata,
        output busy, done, pass, pass_count, fail_count, first_fail_idx, cycle_count
    );

endinterface

// File: rtl/wb_result_checker_check_slot.sv
// One expected-value table entry plus the last value observed for its register or word.
module check_slot
    import wb_checker_pkg::*;
#(
    parameter int XLEN   = CHK_XLEN,
    parameter int REG_AW = 5,
    parameter int DM_AW  = CHK_AW
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic              cfg_valid,
    input  check_kind_e       cfg_kind,
    input  logic [DM_AW-1:0]  cfg_addr,
    input  logic [XLEN-1:0]   cfg_data,
    input  logic              clear,
    input  logic              capture,
    input  logic              rf_we,
    input  logic [REG_AW-1:0] rf_rd,
    input  logic [XLEN-1:0]   rf_wdata,
    input  logic              dm_we,
    input  logic [DM_AW-1:0]  dm_addr,
    input  logic [XLEN-1:0]   dm_wdata,
    output logic              valid,
    output logic              match
);

    check_entry_t    entry;
    logic [XLEN-1:0] observed;
    logic            seen;
    logic            reg_hit;
    logic            mem_hit;
    logic            zero_reg;

    assign zero_reg = (entry.kind == CHK_REG) && (entry.addr[REG_AW-1:0] == '0);
    assign reg_hit  = capture && entry.valid && (entry.kind == CHK_REG) && rf_we &&
                      (rf_rd == entry.addr[REG_AW-1:0]) && (rf_rd != '0);
    assign mem_hit  = capture && entry.valid && (entry.kind == CHK_MEM) && dm_we &&
                      (dm_addr == DM_AW'(entry.addr));

    // NOTE: the table lives in flops rather than RAM, so the async reset can clear it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry <= '0;
        end else if (cfg_we) begin
            entry <= '{valid: cfg_valid, kind: cfg_kind,
                       addr: CHK_AW'(cfg_addr), expected: CHK_XLEN'(cfg_data)};
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            observed <= '0;
            seen     <= 1'b0;
        end else if (clear) begin
            observed <= '0;
            seen     <= 1'b0;
        end else if (reg_hit) begin
            observed <= rf_wdata;
            seen     <= 1'b1;
        end else if (mem_hit) begin
            observed <= dm_wdata;
            seen     <= 1'b1;
        end
    end

    // x0 is hardwired, so its entry compares against a constant zero.
    assign valid = entry.valid;
    assign match = zero_reg ? (XLEN'(entry.expected) == '0)
                            : (seen && (observed == XLEN'(entry.expected)));

endmodule

// File: rtl/wb_result_checker.sv
// Snoops writeback and store ports during a run, then scans the expected-value table one entry per cycle.
module wb_result_checker
    import wb_checker_pkg::*;
#(
    parameter int NUM_CHECKS = 16,
    parameter int XLEN       = CHK_XLEN,
    parameter int REG_AW     = 5,
    parameter int DM_AW      = CHK_AW,
    parameter int TIMEOUT    = 64
)(
    input logic                clock,
    input logic                reset,
    wb_result_checker_if.slave bus
);

    localparam int               IDX_W        = $clog2(NUM_CHECKS);
    localparam int               CNT_W        = $clog2(NUM_CHECKS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CHECKS - 1);
    localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT - 1);

    chk_state_e            state, state_nxt;
    logic [IDX_W-1:0]      scan_idx;
    logic [CNT_W-1:0]      pass_count;
    logic [CNT_W-1:0]      fail_count;
    logic [IDX_W-1:0]      first_fail_idx;
    logic [15:0]           cycle_count;
    logic [NUM_CHECKS-1:0] slot_valid;
    logic [NUM_CHECKS-1:0] slot_match;
    logic                  cfg_write;
    logic                  arm;
    logic                  capture;
    logic                  busy;
    logic                  done;

    assign cfg_write = bus.cfg_we && accepts_cmd(state);
    assign arm       = bus.start && accepts_cmd(state);
    assign capture   = (state == RUN);

    for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_slot
        check_slot #(
            .XLEN   (XLEN),
            .REG_AW (REG_AW),
            .DM_AW  (DM_AW)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .cfg_we    (cfg_write && (bus.cfg_idx == IDX_W'(i))),
            .cfg_valid (bus.cfg_valid),
            .cfg_kind  (bus.cfg_kind),
            .cfg_addr  (bus.cfg_addr),
            .cfg_data  (bus.cfg_data),
            .clear     (arm),
            .capture   (capture),
            .rf_we     (bus.rf_we),
            .rf_rd     (bus.rf_rd),
            .rf_wdata  (bus.rf_wdata),
            .dm_we     (bus.dm_we),
            .dm_addr   (bus.dm_addr),
            .dm_wdata  (bus.dm_wdata),
            .valid     (slot_valid[i]),
            .match     (slot_match[i])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (bus.halt || cycle_count == TIMEOUT_LAST) state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (scan_idx == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_idx       <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            cycle_count    <= '0;
        end else if (arm) begin
            scan_idx       <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            cycle_count    <= '0;
        end else if (state == RUN) begin
            if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
        end else if (state == CHECK) begin
            scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            if (slot_valid[scan_idx]) begin
                if (slot_match[scan_idx]) begin
                    pass_count <= pass_count + 1'b1;
                end else begin
                    if (fail_count == '0) first_fail_idx <= scan_idx;
                    fail_count <= fail_count + 1'b1;
                end
            end
        end
    end

    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = done && (fail_count == '0);
    assign bus.pass_count     = pass_count;
    assign bus.fail_count     = fail_count;
    assign bus.first_fail_idx = first_fail_idx;
    assign bus.cycle_count    = cycle_count;

endmodule
